// File: rtl/wb_scoreboard.sv
// Write-back stage: merges pipeline and long-latency results into one
// register-file write port, tracks outstanding long-latency destinations.
module wb_scoreboard #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_hold,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_wdata,
  output logic        lu_ready,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_wen,
  output logic        id_stall,
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_data,
  output logic [4:0]  regs_rd,
  output logic        regs_wen,
  output logic [31:0] regs_wdata
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic [CNT_W-1:0] cnt;
  logic             lu_grant;
  logic             starve;
  logic             sel_any;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_wdata;

  assign lu_ready  = ~pipe_wen | pipe_hold;
  assign lu_grant  = lu_valid & lu_ready;
  assign starve    = lu_valid & ~lu_ready;
  assign sel_any   = pipe_wen | lu_grant;
  assign sel_rd    = pipe_wen ? pipe_rd : lu_rd;
  assign sel_wdata = pipe_wen ? pipe_wdata : lu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_wen   <= 1'b0;
      regs_rd    <= '0;
      regs_wdata <= '0;
    end else begin
      regs_wen <= sel_any & (sel_rd != 5'd0);
      if (sel_any) begin
        regs_rd    <= sel_rd;
        regs_wdata <= sel_wdata;
      end
    end
  end

  // hold is raised on the edge the wait count reaches the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      pipe_hold <= 1'b0;
    end else begin
      if (starve) begin
        if (cnt != LIMIT)
          cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (lu_grant)
        pipe_hold <= 1'b0;
      else if (starve && cnt == LIMIT_M1)
        pipe_hold <= 1'b1;
    end
  end

  // set after clear so a same-index issue keeps the bit busy
  always_comb begin
    busy_nxt = busy;
    if (lu_grant)
      busy_nxt[lu_rd] = 1'b0;
    if (lu_issue)
      busy_nxt[lu_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  assign id_stall = (busy[id_rs1] & (id_rs1 != 5'd0))
                  | (busy[id_rs2] & (id_rs2 != 5'd0))
                  | (id_wen & (id_rd != 5'd0) & busy[id_rd]);

  assign fwd_rs1_hit = regs_wen & (regs_rd == id_rs1) & (id_rs1 != 5'd0);
  assign fwd_rs2_hit = regs_wen & (regs_rd == id_rs2) & (id_rs2 != 5'd0);
  assign fwd_data    = regs_wdata;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed cases with literal expectations
// plus randomized traffic against a behavioural model.
module tb_wb_scoreboard;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wen = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_wdata = '0;
  logic        pipe_hold;
  logic        lu_valid = 1'b0;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_wdata = '0;
  logic        lu_ready;
  logic        lu_issue = 1'b0;
  logic [4:0]  lu_issue_rd = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic [4:0]  id_rd = '0;
  logic        id_wen = 1'b0;
  logic        id_stall;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_data;
  logic [4:0]  regs_rd;
  logic        regs_wen;
  logic [31:0] regs_wdata;

  wb_scoreboard #(.STARVE_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .pipe_hold(pipe_hold),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
    .lu_ready(lu_ready),
    .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_wen(id_wen),
    .id_stall(id_stall),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_data(fwd_data),
    .regs_rd(regs_rd), .regs_wen(regs_wen), .regs_wdata(regs_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // behavioural model
  bit          m_busy [32];
  int          m_wait;
  bit          m_hold;
  bit          m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wait = 0;
      m_hold = 0;
      m_wen  = 0;
      m_rd   = '0;
      m_wd   = '0;
    end else begin
      bit          rdy;
      bit          wr;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      rdy  = !pipe_wen || m_hold;
      wr   = pipe_wen || (lu_valid && rdy);
      wrd  = pipe_wen ? pipe_rd : lu_rd;
      wdat = pipe_wen ? pipe_wdata : lu_wdata;
      m_wen = wr && (wrd != 0);
      if (wr) begin
        m_rd = wrd;
        m_wd = wdat;
      end
      if (lu_valid && rdy) m_busy[lu_rd] = 0;
      if (lu_issue && lu_issue_rd != 0) m_busy[lu_issue_rd] = 1;
      if (lu_valid && !rdy) begin
        if (m_wait < LIM) m_wait++;
        if (m_wait == LIM && !m_hold) m_hold = 1;
      end else begin
        m_wait = 0;
      end
      if (lu_valid && rdy) m_hold = 0;
    end
  end

  function automatic bit exp_stall();
    return (m_busy[id_rs1] && id_rs1 != 0) ||
           (m_busy[id_rs2] && id_rs2 != 0) ||
           (id_wen && id_rd != 0 && m_busy[id_rd]);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("lu_ready", 32'(lu_ready), 32'(!pipe_wen || m_hold));
      chk("pipe_hold", 32'(pipe_hold), 32'(m_hold));
      chk("id_stall", 32'(id_stall), 32'(exp_stall()));
      chk("fwd_rs1_hit", 32'(fwd_rs1_hit),
          32'(m_wen && m_rd == id_rs1 && id_rs1 != 0));
      chk("fwd_rs2_hit", 32'(fwd_rs2_hit),
          32'(m_wen && m_rd == id_rs2 && id_rs2 != 0));
      chk("fwd_data", fwd_data, m_wd);
      chk("regs_wen", 32'(regs_wen), 32'(m_wen));
      chk("regs_rd", 32'(regs_rd), 32'(m_rd));
      chk("regs_wdata", regs_wdata, m_wd);
    end
  end

  always @(negedge clk)
    if (rst_n)
      assert (!(pipe_wen && pipe_hold))
        else $error("protocol: pipe_wen while pipe_hold");

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit g;

  initial begin
    #12;
    chk("rst regs_wen", 32'(regs_wen), 32'd0);
    chk("rst regs_rd", 32'(regs_rd), 32'd0);
    chk("rst regs_wdata", regs_wdata, 32'd0);
    chk("rst pipe_hold", 32'(pipe_hold), 32'd0);
    chk("rst id_stall", 32'(id_stall), 32'd0);
    rst_n = 1'b1;
    step();

    // pipeline write
    pipe_wen = 1; pipe_rd = 5; pipe_wdata = 32'hDEADBEEF;
    step();
    pipe_wen = 0;
    @(negedge clk);
    chk("t1 wen", 32'(regs_wen), 32'd1);
    chk("t1 rd", 32'(regs_rd), 32'd5);
    chk("t1 data", regs_wdata, 32'hDEADBEEF);
    step();
    @(negedge clk);
    chk("t1 wen after", 32'(regs_wen), 32'd0);
    step();

    // x0 write dropped
    pipe_wen = 1; pipe_rd = 0; pipe_wdata = 32'h1234; id_rs1 = 0;
    @(negedge clk);
    chk("t2 wen pre", 32'(regs_wen), 32'd0);
    step();
    pipe_wen = 0;
    @(negedge clk);
    chk("t2 wen", 32'(regs_wen), 32'd0);
    chk("t2 hit", 32'(fwd_rs1_hit), 32'd0);
    step();

    // scoreboard RAW then bypass
    lu_issue = 1; lu_issue_rd = 7;
    step();
    lu_issue = 0; id_rs1 = 7;
    @(negedge clk);
    chk("t3 stall", 32'(id_stall), 32'd1);
    step();
    lu_valid = 1; lu_rd = 7; lu_wdata = 32'h55;
    @(negedge clk);
    chk("t3 ready", 32'(lu_ready), 32'd1);
    step();
    lu_valid = 0;
    @(negedge clk);
    chk("t3 stall clr", 32'(id_stall), 32'd0);
    chk("t3 wen", 32'(regs_wen), 32'd1);
    chk("t3 rd", 32'(regs_rd), 32'd7);
    chk("t3 data", regs_wdata, 32'h55);
    chk("t3 hit", 32'(fwd_rs1_hit), 32'd1);
    chk("t3 fwd", fwd_data, 32'h55);
    step();
    id_rs1 = 0;

    // starvation
    pipe_wen = 1; pipe_rd = 1; pipe_wdata = 32'h11;
    lu_valid = 1; lu_rd = 2; lu_wdata = 32'hAA;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      chk("t4 starved", 32'(lu_ready), 32'd0);
      chk("t4 no hold", 32'(pipe_hold), 32'd0);
      step();
    end
    chk("t4 hold", 32'(pipe_hold), 32'd1);
    pipe_wen = 0;
    @(negedge clk);
    chk("t4 ready", 32'(lu_ready), 32'd1);
    step();
    lu_valid = 0;
    @(negedge clk);
    chk("t4 wen", 32'(regs_wen), 32'd1);
    chk("t4 rd", 32'(regs_rd), 32'd2);
    chk("t4 data", regs_wdata, 32'hAA);
    chk("t4 hold clr", 32'(pipe_hold), 32'd0);
    step();

    // set wins over clear
    lu_issue = 1; lu_issue_rd = 9;
    lu_valid = 1; lu_rd = 9; lu_wdata = 32'h99;
    step();
    lu_issue = 0; lu_valid = 0; id_rs2 = 9;
    @(negedge clk);
    chk("t5 stall", 32'(id_stall), 32'd1);
    step();

    // randomized traffic
    g = 0;
    for (int n = 0; n < 400; n++) begin
      if (g || !lu_valid) begin
        lu_valid = ($urandom % 3) == 0;
        lu_rd    = 5'($urandom % 8);
        lu_wdata = $urandom;
      end
      pipe_wen    = !pipe_hold && (($urandom % 5) != 0);
      pipe_rd     = 5'($urandom % 8);
      pipe_wdata  = $urandom;
      lu_issue    = ($urandom % 4) == 0;
      lu_issue_rd = 5'($urandom % 8);
      id_rs1      = 5'($urandom % 8);
      id_rs2      = 5'($urandom % 8);
      id_rd       = 5'($urandom % 8);
      id_wen      = 1'($urandom);
      @(negedge clk);
      g = lu_valid && lu_ready;
      step();
    end
    pipe_wen = 0; lu_valid = 0; lu_issue = 0; id_wen = 0; id_rs2 = 0;
    step();
    step();

    // async reset mid-transfer
    lu_issue = 1; lu_issue_rd = 3;
    step();
    lu_issue = 0; pipe_wen = 1; pipe_rd = 4; pipe_wdata = 32'hCAFE;
    step();
    pipe_wen = 0; id_rs1 = 3;
    #1;
    chk("t6 wen pre", 32'(regs_wen), 32'd1);
    chk("t6 stall pre", 32'(id_stall), 32'd1);
    #1;
    rst_n = 0;
    #1;
    chk("t6 wen rst", 32'(regs_wen), 32'd0);
    chk("t6 rd rst", 32'(regs_rd), 32'd0);
    chk("t6 stall rst", 32'(id_stall), 32'd0);
    step();
    rst_n = 1;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
